// File: rtl/vga_compositor.sv
// -----------------------------------------------------------------------------
// vga_compositor
//
// Configurable VGA timing generator with an N-layer fixed-priority compositor.
// The x/y counters drive the upstream layer sources. Their answers come back
// LAYER_LAT cycles later. The winning layer colour then passes through a
// two-stage pipeline. The raw syncs and display enable are delayed by the same
// amount, so hsync/vsync/de leave the block aligned with rgb.
//
// Optional feature (macro VGA_COLORKEY_EN):
//   When defined, the key_rgb port is added. A layer whose colour equals
//   key_rgb is treated as transparent for that pixel.
//
// Ports:
//   dclk        in   pixel clock
//   rst         in   asynchronous, active-high reset
//   layer_on    in   per-layer coverage of the pixel answered this cycle
//   layer_rgb   in   per-layer colour, layer i at [i*RGB_W +: RGB_W]
//   layer_mask  in   per-layer enable, captured once per frame at frame_start
//   bg_rgb      in   background colour, used when no layer qualifies
//   key_rgb     in   transparent colour key (VGA_COLORKEY_EN only)
//   x, y        out  pixel counters presented to the layer sources
//   frame_start out  high while x=0 and y=0 (not delayed)
//   hsync       out  horizontal sync, SYNC_POL when asserted, aligned to rgb
//   vsync       out  vertical sync, SYNC_POL when asserted, aligned to rgb
//   de          out  display enable, aligned to rgb
//   rgb         out  composited pixel, forced to 0 outside the active area
// -----------------------------------------------------------------------------
module vga_compositor #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 29,
  parameter int SYNC_POL  = 0,
  parameter int N_LAYERS  = 12,
  parameter int RGB_W     = 8,
  parameter int LAYER_LAT = 1
) (
  input  logic                        dclk,
  input  logic                        rst,
  input  logic [N_LAYERS-1:0]         layer_on,
  input  logic [N_LAYERS*RGB_W-1:0]   layer_rgb,
  input  logic [N_LAYERS-1:0]         layer_mask,
  input  logic [RGB_W-1:0]            bg_rgb,
`ifdef VGA_COLORKEY_EN
  input  logic [RGB_W-1:0]            key_rgb,
`endif
  output logic [10:0]                 x,
  output logic [10:0]                 y,
  output logic                        frame_start,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        de,
  output logic [RGB_W-1:0]            rgb
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam int DLY_N = (LAYER_LAT > 0) ? LAYER_LAT : 1;

  localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOT - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_ON = (SYNC_POL != 0);

  // Control bundles carry active-high flags: [2]=hsync, [1]=vsync, [0]=de.
  logic [10:0]               x_q, x_d, y_q, y_d;
  logic [N_LAYERS-1:0]       mask_q, mask_d;
  logic [2:0]                ctl_raw, ctl_lat;
  logic [2:0]                dly_q [DLY_N];
  logic [2:0]                dly_d [DLY_N];
  logic [N_LAYERS-1:0]       qual;
  logic                      hit;
  logic [IDX_W-1:0]          idx;

  logic [IDX_W-1:0]          idx_p1_q, idx_p1_d;
  logic                      hit_p1_q, hit_p1_d;
  logic [N_LAYERS*RGB_W-1:0] lrgb_p1_q, lrgb_p1_d;
  logic [RGB_W-1:0]          bg_p1_q, bg_p1_d;
  logic [2:0]                ctl_p1_q, ctl_p1_d;

  logic [RGB_W-1:0]          sel_rgb;
  logic [RGB_W-1:0]          rgb_p2_q, rgb_p2_d;
  logic [2:0]                ctl_p2_q, ctl_p2_d;

  // Both counters wrap together at the last pixel of the last line.
  always_comb begin
    x_d = x_q + 11'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? 11'd0 : y_q + 11'd1;
    end
  end

  assign frame_start = (x_q == 11'd0) && (y_q == 11'd0);

  always_comb begin
    ctl_raw    = '0;
    ctl_raw[2] = (x_q >= HS_BEG) && (x_q < HS_END);
    ctl_raw[1] = (y_q >= VS_BEG) && (y_q < VS_END);
    ctl_raw[0] = (x_q < H_ACT) && (y_q < V_ACT);
  end

  // The mask is latched only at the frame origin, so a frame never mixes two
  // different mask settings.
  always_comb begin
    mask_d = mask_q;
    if (frame_start) mask_d = layer_mask;
  end

  // Delay raw controls by LAYER_LAT so they meet the layer data they belong to.
  always_comb begin
    dly_d[0] = ctl_raw;
    for (int i = 1; i < DLY_N; i++) dly_d[i] = dly_q[i-1];
  end

  assign ctl_lat = (LAYER_LAT == 0) ? ctl_raw : dly_q[DLY_N-1];

  // The lowest qualifying index wins. Scanning downward lets lower indices
  // overwrite higher ones.
  always_comb begin
    qual = layer_on & mask_q;
`ifdef VGA_COLORKEY_EN
    for (int i = 0; i < N_LAYERS; i++) begin
      if (layer_rgb[i*RGB_W +: RGB_W] == key_rgb) qual[i] = 1'b0;
    end
`endif
    hit = |qual;
    idx = '0;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (qual[i]) idx = IDX_W'(i);
    end
  end

  // ---- Stage A: winner index, sampled layer colours, delayed controls ----
  always_comb begin
    idx_p1_d  = idx;
    hit_p1_d  = hit;
    lrgb_p1_d = layer_rgb;
    bg_p1_d   = bg_rgb;
    ctl_p1_d  = ctl_lat;
  end

  // ---- Stage B: colour mux and blanking, output controls ----
  always_comb begin
    sel_rgb  = hit_p1_q ? lrgb_p1_q[idx_p1_q*RGB_W +: RGB_W] : bg_p1_q;
    rgb_p2_d = ctl_p1_q[0] ? sel_rgb : '0;
    ctl_p2_d = ctl_p1_q;
  end

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      mask_q    <= '1;
      for (int i = 0; i < DLY_N; i++) dly_q[i] <= '0;
      idx_p1_q  <= '0;
      hit_p1_q  <= 1'b0;
      lrgb_p1_q <= '0;
      bg_p1_q   <= '0;
      ctl_p1_q  <= '0;
      rgb_p2_q  <= '0;
      ctl_p2_q  <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      mask_q    <= mask_d;
      for (int i = 0; i < DLY_N; i++) dly_q[i] <= dly_d[i];
      idx_p1_q  <= idx_p1_d;
      hit_p1_q  <= hit_p1_d;
      lrgb_p1_q <= lrgb_p1_d;
      bg_p1_q   <= bg_p1_d;
      ctl_p1_q  <= ctl_p1_d;
      rgb_p2_q  <= rgb_p2_d;
      ctl_p2_q  <= ctl_p2_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign rgb   = rgb_p2_q;
  assign de    = ctl_p2_q[0];
  assign hsync = ctl_p2_q[2] ? SYNC_ON : ~SYNC_ON;
  assign vsync = ctl_p2_q[1] ? SYNC_ON : ~SYNC_ON;

endmodule

// File: tb/tb_vga_compositor.sv
// -----------------------------------------------------------------------------
// tb_vga_compositor
//
// Self-checking bench for vga_compositor. The bench uses a shrunken raster so
// that several whole frames fit in a short run. The reference model derives
// every expected output from the cycle number since reset release, the layer
// inputs recorded per cycle, and the per-frame mask rule.
// -----------------------------------------------------------------------------
module tb_vga_compositor;

  localparam int HA = 16, HF = 4, HS = 6, HB = 5;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int N  = 12;
  localparam int W  = 8;

  logic           dclk = 1'b0;
  logic           rst  = 1'b1;
  logic [N-1:0]   layer_on   = '0;
  logic [N*W-1:0] layer_rgb  = '0;
  logic [N-1:0]   layer_mask = '1;
  logic [W-1:0]   bg_rgb     = '0;
`ifdef VGA_COLORKEY_EN
  logic [W-1:0]   key_rgb    = 8'h5A;
`endif
  logic [10:0]    x, y;
  logic           frame_start, hsync, vsync, de;
  logic [W-1:0]   rgb;

  always #5 dclk = ~dclk;

  vga_compositor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .N_LAYERS(N), .RGB_W(W), .LAYER_LAT(1)
  ) dut (
    .dclk(dclk), .rst(rst),
    .layer_on(layer_on), .layer_rgb(layer_rgb), .layer_mask(layer_mask),
    .bg_rgb(bg_rgb),
`ifdef VGA_COLORKEY_EN
    .key_rgb(key_rgb),
`endif
    .x(x), .y(y), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb)
  );

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;

  // History of the last 8 cycles of inputs plus the mask in force for each.
  logic [N-1:0]   r_on   [8];
  logic [N*W-1:0] r_rgb  [8];
  logic [W-1:0]   r_bg   [8];
  logic [N-1:0]   r_m    [8];
`ifdef VGA_COLORKEY_EN
  logic [W-1:0]   r_key  [8];
`endif
  logic [N-1:0]   shadow_m = '1;

  // Apply inputs for cycle cyc and record them. A mask offered on a frame
  // start cycle governs data from the following cycle onward.
  task automatic apply(input logic [N-1:0] on, input logic [N*W-1:0] lr,
                       input logic [W-1:0] bg, input logic [N-1:0] m);
    layer_on = on; layer_rgb = lr; bg_rgb = bg; layer_mask = m;
    r_on[cyc & 7] = on; r_rgb[cyc & 7] = lr; r_bg[cyc & 7] = bg;
    r_m[cyc & 7]  = shadow_m;
`ifdef VGA_COLORKEY_EN
    r_key[cyc & 7] = key_rgb;
`endif
    if (cyc % FT == 0) shadow_m = m;
  endtask

  task automatic drive(input logic [N-1:0] on, input logic [N*W-1:0] lr,
                       input logic [W-1:0] bg, input logic [N-1:0] m);
    @(negedge dclk);
    cyc++;
    apply(on, lr, bg, m);
  endtask

  task automatic drive_rand();
    drive(12'($urandom() & $urandom()), {$urandom(), $urandom(), $urandom()},
          8'($urandom()), 12'($urandom()));
  endtask

  task automatic release_rst();
    @(negedge dclk);
    rst = 1'b0;
    cyc = 0;
    shadow_m = '1;
    apply(12'($urandom()), {$urandom(), $urandom(), $urandom()}, 8'($urandom()), '1);
  endtask

  // Reference: output cycle c shows pixel c-3 built from data offered in c-2.
  function automatic void exp_at(input int c, output logic [10:0] ex,
                                 output logic [10:0] ey, output logic efs,
                                 output logic ehs, output logic evs,
                                 output logic ede, output logic [7:0] ergb);
    int px, py, d;
    logic found, ok;
    logic [7:0] col;
    ex = 11'(c % HT);
    ey = 11'((c / HT) % VT);
    efs = (ex == 11'd0) && (ey == 11'd0);
    ehs = 1'b1; evs = 1'b1; ede = 1'b0; ergb = 8'h00;
    if (c >= 3) begin
      px  = (c - 3) % HT;
      py  = ((c - 3) / HT) % VT;
      d   = (c - 2) & 7;
      ehs = !(px >= HA + HF && px < HA + HF + HS);
      evs = !(py >= VA + VF && py < VA + VF + VS);
      ede = (px < HA) && (py < VA);
      col = r_bg[d];
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        ok = r_on[d][i] && r_m[d][i];
`ifdef VGA_COLORKEY_EN
        if (r_rgb[d][i*W +: W] == r_key[d]) ok = 1'b0;
`endif
        if (!found && ok) begin
          col = r_rgb[d][i*W +: W];
          found = 1'b1;
        end
      end
      ergb = ede ? col : 8'h00;
    end
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge dclk);
    vec++; if (x !== 11'd0) begin miss++; $display("FAIL reset_x got %0d want 0", x); end
    vec++; if (y !== 11'd0) begin miss++; $display("FAIL reset_y got %0d want 0", y); end
    vec++; if (frame_start !== 1'b1) begin miss++; $display("FAIL reset_fs got %b want 1", frame_start); end
    vec++; if (rgb !== 8'h00) begin miss++; $display("FAIL reset_rgb got %h want 00", rgb); end
    vec++; if (de !== 1'b0) begin miss++; $display("FAIL reset_de got %b want 0", de); end
    vec++; if (hsync !== 1'b1) begin miss++; $display("FAIL reset_hsync got %b want 1", hsync); end
    vec++; if (vsync !== 1'b1) begin miss++; $display("FAIL reset_vsync got %b want 1", vsync); end
    release_rst();
    vec++;
    if (x !== 11'd0 || y !== 11'd0 || de !== 1'b0 || rgb !== 8'h00) begin
      miss++; $display("FAIL release_c0 got x=%0d y=%0d de=%b rgb=%h want 0 0 0 00", x, y, de, rgb);
    end
  endtask

  task automatic test_timing();
    logic [10:0] ex, ey; logic efs, ehs, evs, ede; logic [7:0] ergb;
    int hs_run = 0, vs_run = 0, de_run = 0, last_fs = 0;
    for (int k = 0; k < 2 * FT + 10; k++) begin
      drive_rand();
      exp_at(cyc, ex, ey, efs, ehs, evs, ede, ergb);
      vec++;
      if ({x, y, frame_start, hsync, vsync, de, rgb} !== {ex, ey, efs, ehs, evs, ede, ergb}) begin
        miss++;
        $display("FAIL timing c=%0d got x=%0d y=%0d fs=%b hs=%b vs=%b de=%b rgb=%h want x=%0d y=%0d fs=%b hs=%b vs=%b de=%b rgb=%h",
                 cyc, x, y, frame_start, hsync, vsync, de, rgb, ex, ey, efs, ehs, evs, ede, ergb);
      end
      if (hsync === 1'b0) hs_run++;
      else if (hs_run != 0) begin
        vec++; if (hs_run !== HS) begin miss++; $display("FAIL hsync_width got %0d want %0d", hs_run, HS); end
        hs_run = 0;
      end
      if (vsync === 1'b0) vs_run++;
      else if (vs_run != 0) begin
        vec++; if (vs_run !== VS * HT) begin miss++; $display("FAIL vsync_width got %0d want %0d", vs_run, VS * HT); end
        vs_run = 0;
      end
      if (de === 1'b1) de_run++;
      else if (de_run != 0) begin
        vec++; if (de_run !== HA) begin miss++; $display("FAIL de_width got %0d want %0d", de_run, HA); end
        de_run = 0;
      end
      if (frame_start === 1'b1) begin
        vec++; if (cyc - last_fs !== FT) begin miss++; $display("FAIL frame_period got %0d want %0d", cyc - last_fs, FT); end
        last_fs = cyc;
      end
    end
  endtask

  task automatic test_priority();
    logic [10:0] ex, ey; logic efs, ehs, evs, ede; logic [7:0] ergb, want;
    logic [N*W-1:0] lr;
    int f_next, bound;
    lr = {$urandom(), $urandom(), $urandom()};
    lr[2*W +: W] = 8'hE0;
    lr[3*W +: W] = 8'h1C;
    for (int k = 0; k < FT + 5; k++) drive(12'h00C, lr, 8'h55, '1);
    bound = 0;
    while (((cyc % FT) / HT) != 3 && bound < FT) begin
      drive(12'h00C, lr, 8'h55, '1);
      bound++;
    end
    vec++; if (bound >= FT) begin miss++; $display("FAIL prio_seek got %0d want <%0d", bound, FT); end
    // Mask bit 2 cleared mid-frame; it must only bite after the next frame start.
    f_next = (cyc / FT + 1) * FT;
    while (cyc < f_next + FT) begin
      drive(12'h00C, lr, 8'h55, ~12'h004);
      exp_at(cyc, ex, ey, efs, ehs, evs, ede, ergb);
      want = ede ? (((cyc - 2) > f_next) ? 8'h1C : 8'hE0) : 8'h00;
      vec++;
      if (rgb !== want) begin miss++; $display("FAIL priority c=%0d got %h want %h", cyc, rgb, want); end
    end
  endtask

  task automatic test_background();
    logic [10:0] ex, ey; logic efs, ehs, evs, ede; logic [7:0] ergb, want;
    for (int k = 0; k < FT / 2; k++) begin
      drive('0, {$urandom(), $urandom(), $urandom()}, 8'h03, 12'($urandom()));
      exp_at(cyc, ex, ey, efs, ehs, evs, ede, ergb);
      want = ede ? 8'h03 : 8'h00;
      if (k >= 3) begin
        vec++;
        if (rgb !== want) begin miss++; $display("FAIL background c=%0d got %h want %h", cyc, rgb, want); end
      end
    end
  endtask

  task automatic test_blanking();
    logic [10:0] ex, ey; logic efs, ehs, evs, ede; logic [7:0] ergb, want;
    logic [N*W-1:0] lr;
    lr = {$urandom(), $urandom(), $urandom()};
    lr[0 +: W] = 8'hAB;
    for (int k = 0; k < FT / 2; k++) begin
      drive('1, lr, 8'h77, '1);
      exp_at(cyc, ex, ey, efs, ehs, evs, ede, ergb);
      want = ede ? 8'hAB : 8'h00;
      if (k >= 3) begin
        vec++;
        if (rgb !== want) begin miss++; $display("FAIL blanking c=%0d got %h want %h", cyc, rgb, want); end
      end
    end
  endtask

  task automatic test_latency();
    logic [10:0] ex, ey; logic efs, ehs, evs, ede; logic [7:0] ergb, want;
    logic [N*W-1:0] lr;
    for (int k = 0; k < FT / 2; k++) begin
      // Source model: answers with the x it saw one cycle earlier.
      lr = {$urandom(), $urandom(), $urandom()};
      lr[0 +: W] = 8'(cyc % HT);
      drive(12'h001, lr, 8'h99, '1);
      exp_at(cyc, ex, ey, efs, ehs, evs, ede, ergb);
      want = ede ? 8'((cyc - 3) % HT) : 8'h00;
      if (k >= 3) begin
        vec++;
        if (rgb !== want || de !== ede) begin
          miss++; $display("FAIL latency c=%0d got rgb=%h de=%b want rgb=%h de=%b", cyc, rgb, de, want, ede);
        end
      end
    end
  endtask

  task automatic test_colorkey();
    logic [10:0] ex, ey; logic efs, ehs, evs, ede; logic [7:0] ergb, want;
    logic [N*W-1:0] lr;
    lr = {$urandom(), $urandom(), $urandom()};
    lr[0 +: W] = 8'hFF;
    lr[W +: W] = 8'h10;
`ifdef VGA_COLORKEY_EN
    key_rgb = 8'hFF;
`endif
    for (int k = 0; k < FT / 2; k++) begin
      drive(12'h003, lr, 8'h42, '1);
      exp_at(cyc, ex, ey, efs, ehs, evs, ede, ergb);
`ifdef VGA_COLORKEY_EN
      want = ede ? 8'h10 : 8'h00;
`else
      want = ede ? 8'hFF : 8'h00;
`endif
      if (k >= 3) begin
        vec++;
        if (rgb !== want) begin miss++; $display("FAIL colorkey c=%0d got %h want %h", cyc, rgb, want); end
      end
    end
`ifdef VGA_COLORKEY_EN
    key_rgb = 8'h5A;
`endif
  endtask

  task automatic test_reset_mid();
    logic [10:0] ex, ey; logic efs, ehs, evs, ede; logic [7:0] ergb;
    int bound = 0;
    while (!((cyc % HT) == 12 && ((cyc / HT) % VT) == 5) && bound < 2 * FT) begin
      drive_rand();
      bound++;
    end
    vec++; if (bound >= 2 * FT) begin miss++; $display("FAIL rstmid_seek got %0d want <%0d", bound, 2 * FT); end
    rst = 1'b1;
    #1;
    vec++;
    if ({x, y, frame_start, hsync, vsync, de, rgb} !== {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00}) begin
      miss++;
      $display("FAIL rstmid_now got x=%0d y=%0d fs=%b hs=%b vs=%b de=%b rgb=%h want 0 0 1 1 1 0 00",
               x, y, frame_start, hsync, vsync, de, rgb);
    end
    repeat (2) @(negedge dclk);
    release_rst();
    for (int k = 0; k < 3 * HT; k++) begin
      drive_rand();
      exp_at(cyc, ex, ey, efs, ehs, evs, ede, ergb);
      vec++;
      if ({x, y, frame_start, hsync, vsync, de, rgb} !== {ex, ey, efs, ehs, evs, ede, ergb}) begin
        miss++;
        $display("FAIL rstmid_run c=%0d got x=%0d y=%0d de=%b rgb=%h want x=%0d y=%0d de=%b rgb=%h",
                 cyc, x, y, de, rgb, ex, ey, ede, ergb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_priority();
    test_background();
    test_blanking();
    test_latency();
    test_colorkey();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/vga_compositor.md
# vga_compositor

Parametrised VGA timing generator and N-layer priority compositor for the display path. Replaces the fixed 640x480 counter, hard-wired sync decode and hand-written layer if/else chain with configurable timing, a masked fixed-priority layer select and a pipelined output whose syncs stay aligned with pixel data. Sprite, score, overlay and background sources sit upstream and read `x`/`y`. The VGA pins sit downstream.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, hsync pulse width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vsync pulse width
- `V_BP`, 29, vertical back porch
- `SYNC_POL`, 0, asserted sync level (0 = active low)
- `N_LAYERS`, 12, number of layer inputs (1..16)
- `RGB_W`, 8, colour width
- `LAYER_LAT`, 1, source latency in cycles from `x`/`y` to `layer_*`/`bg_rgb` (0..3)

Ports. Reset is rst, asynchronous, active-high. The clock is dclk.
- `dclk` in 1: pixel clock
- `rst` in 1: asynchronous, active-high reset
- `layer_on` in N_LAYERS: layer i covers the current pixel
- `layer_rgb` in N_LAYERS*RGB_W: layer i colour, in bits [i*RGB_W +: RGB_W]
- `layer_mask` in N_LAYERS: layer i is enabled; sampled at frame start
- `bg_rgb` in RGB_W: background colour
- `x` out 11: horizontal counter
- `y` out 11: vertical counter
- `frame_start` out 1: one-cycle pulse when x=0 and y=0
- `hsync` out 1: aligned to `rgb`
- `vsync` out 1: aligned to `rgb`
- `de` out 1: display enable, aligned to `rgb`
- `rgb` out RGB_W: output pixel

## Operation
- Totals:
  - H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800)
  - V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP (default 521)
- `x` increments every cycle. At H_TOT-1 it wraps to 0 and `y` increments.
- `y` wraps to 0 after V_TOT-1. Wrap of both counters is simultaneous at (H_TOT-1, V_TOT-1).
- Region order on each axis is active, then front porch, then sync, then back porch.
- Raw signals, decoded from the counters:
  - raw hsync: x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - raw vsync: y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
  - raw de: x<H_ACTIVE and y<V_ACTIVE
- Mask shadow: `layer_mask` is captured into a shadow register in the cycle `frame_start` is high. The shadow is used for the whole frame, so a mid-frame change causes no tearing.
- Select: the winner is the lowest index i with `layer_on[i]` and shadow mask[i] both set. If no layer qualifies, `bg_rgb` is used.
- If delayed de is 0, `rgb` is forced to 0 regardless of the layers.
- Pipeline:
  - raw hsync, vsync and de are delayed LAYER_LAT cycles to meet the sampled layer data.
  - Stage A registers the winner index plus the delayed controls.
  - Stage B registers `rgb`, `hsync`, `vsync` and `de`.
- Sync outputs drive SYNC_POL when asserted and ~SYNC_POL otherwise.

## Timing
- Reset values:
  - x=0, y=0
  - `frame_start`=1 (combinational from the counters)
  - `rgb`=0, `de`=0
  - `hsync` and `vsync` at the deasserted level ~SYNC_POL
  - mask shadow = all ones
  - all delay and pipeline registers cleared, with syncs deasserted
- Latency: the `x`/`y` value presented in cycle n appears on `rgb`/`hsync`/`vsync`/`de` in cycle n+LAYER_LAT+2.
- With the defaults (LAYER_LAT=1), outputs are valid 3 cycles after reset release.
- Reset asserted mid-frame clears all state immediately. Counting restarts at (0,0) on the first `dclk` edge after release.
- `layer_on`/`layer_rgb` are sampled once, LAYER_LAT cycles after the `x` they answer. No handshake; sources must meet this latency.
- `frame_start` is not delayed; it is aligned with `x`/`y`.

## Configuration
- `VGA_COLORKEY_EN`
  - Defined: adds port `key_rgb` in RGB_W. A layer whose `layer_rgb` equals `key_rgb` is treated as not on, so selection falls through to the next layer or the background. This gives transparent sprite pixels.
  - Undefined: the port is absent and only `layer_on` decides coverage.

## Test plan
- Timing: reset, run one frame with defaults.
  - hsync low for exactly 96 cycles starting at x=656 (delayed 3 cycles on the output).
  - vsync low for lines 490-491.
  - 800x521 cycles between `frame_start` pulses.
  - `de` high 640 cycles per line for 480 lines.
- Priority:
  - `layer_on`=12'h00C, layer2=8'hE0, layer3=8'h1C: `rgb`=8'hE0.
  - Clear bit 2 of `layer_mask` before `frame_start`: `rgb`=8'h1C from the next frame.
  - Changing the mask mid-frame has no effect until the next frame.
- Background and blanking:
  - `layer_on`=0, `bg_rgb`=8'h03: `rgb`=8'h03 in the active area.
  - At x=700 with all layers on: `rgb`=0.
- Latency: a layer model returns x[7:0] after 1 cycle. Check `rgb` equals the x value from 3 cycles earlier and is aligned with `de`.
- Reset mid-line:
  - Assert `rst` at x=300, y=100: outputs take their reset values at once.
  - After release, x and y count from 0.
- `VGA_COLORKEY_EN`: `key_rgb`=8'hFF, layer0=8'hFF, layer1=8'h10, both on. `rgb`=8'h10. With the macro undefined, `rgb`=8'hFF.
